bitwise_logic_unit: RTL and testbench

//  Parametrised successor to the fixed 8-bit AND slice behind the TT wrapper.
//  - Configurable WIDTH; four bitwise ops (AND/OR/XOR/XNOR).
//  - Two modes: pairwise (Y = a OP b per beat) and burst-reduce (Y = OP over all a beats).
//  - Registered result behind a valid/ready handshake.
//  - Sits between ui_in/uio_in and uo_out in the top-level wrapper.

---
 rtl/bitwise_logic_unit.sv | 144 ++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// Parametrised bitwise AND/OR/XOR/XNOR unit with pairwise and burst-reduce modes.
// Optional popcount output port enabled by defining BLU_POPCOUNT_EN.
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             mode,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] count
`ifdef BLU_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic [1:0]       burst_op, burst_op_n;
  logic             out_valid_n;
  logic [WIDTH-1:0] y_n;
  logic [CNT_W-1:0] count_n;
  logic             fire;
  logic [WIDTH-1:0] reduced;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
    case (sel)
      OP_AND:  apply_op = x & z;
      OP_OR:   apply_op = x | z;
      OP_XOR:  apply_op = x ^ z;
      default: apply_op = ~(x ^ z);
    endcase
  endfunction

  // Single output register: accept a beat whenever it is empty or draining.
  assign in_ready = ~out_valid | out_ready;
  assign fire     = in_valid & in_ready;
  assign reduced  = apply_op(burst_op, acc, a);

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    beat_cnt_n  = beat_cnt;
    burst_op_n  = burst_op;
    out_valid_n = out_valid & ~out_ready;
    y_n         = Y;
    count_n     = count;
    if (fire) begin
      case (state)
        IDLE: begin
          if (!mode) begin
            y_n         = apply_op(op, a, b);
            count_n     = CNT_W'(1);
            out_valid_n = 1'b1;
          end else begin
            acc_n      = a;
            beat_cnt_n = CNT_W'(1);
            burst_op_n = op;
            if (in_last) begin
              y_n         = a;
              count_n     = CNT_W'(1);
              out_valid_n = 1'b1;
            end else begin
              state_n = ACCUM;
            end
          end
        end
        default: begin
          // op/mode are ignored here; the burst only ends on in_last.
          acc_n      = reduced;
          beat_cnt_n = (&beat_cnt) ? beat_cnt : beat_cnt + CNT_W'(1);
          if (in_last) begin
            y_n         = reduced;
            count_n     = beat_cnt_n;
            out_valid_n = 1'b1;
            state_n     = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      burst_op  <= '0;
      out_valid <= 1'b0;
      Y         <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      beat_cnt  <= beat_cnt_n;
      burst_op  <= burst_op_n;
      out_valid <= out_valid_n;
      Y         <= y_n;
      count     <= count_n;
    end
  end

`ifdef BLU_POPCOUNT_EN
  localparam int unsigned PC_W = $clog2(WIDTH + 1);

  logic [PC_W-1:0] popcnt_n;

  // Popcount of the next result, registered alongside Y.
  always_comb begin
    popcnt_n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      popcnt_n = popcnt_n + PC_W'(y_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      popcnt <= '0;
    end else begin
      popcnt <= popcnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed cases then random traffic
// against a burst-queue reference model; two instances (CNT_W=8 and CNT_W=2).
module tb_bitwise_logic_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv, il, md, ordy;
  logic [1:0] opv;
  logic [7:0] av, bv;

  logic       in_ready1, out_valid1, in_ready2, out_valid2;
  logic [7:0] y1, y2;
  logic [7:0] count1;
  logic [1:0] count2;
`ifdef BLU_POPCOUNT_EN
  logic [3:0] popcnt1, popcnt2;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: pending output and the beats of the open burst.
  logic       m_valid;
  logic [7:0] m_y;
  int         m_cnt;
  logic [1:0] m_bop;
  logic [7:0] q[$];
  logic       exp_rdy;
  logic       primed;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(8), .CNT_W(8)) dut1 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(in_ready1), .in_last(il),
    .mode(md), .op(opv), .a(av), .b(bv), .out_valid(out_valid1),
    .out_ready(ordy), .Y(y1), .count(count1)
`ifdef BLU_POPCOUNT_EN
    , .popcnt(popcnt1)
`endif
  );

  bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(in_ready2), .in_last(il),
    .mode(md), .op(opv), .a(av), .b(bv), .out_valid(out_valid2),
    .out_ready(ordy), .Y(y2), .count(count2)
`ifdef BLU_POPCOUNT_EN
    , .popcnt(popcnt2)
`endif
  );

  function automatic logic [7:0] f_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: check in_ready before the edge, update the model, check outputs.
  task automatic step();
    logic [7:0] r;
    exp_rdy = !m_valid || ordy;
    #1;
    if (primed) begin
      chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
      chk("in_ready2", 32'(in_ready2), 32'(exp_rdy));
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_y     = '0;
      m_cnt   = 0;
      q.delete();
      primed  = 1'b1;
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (iv && exp_rdy) begin
        if (q.size() == 0 && !md) begin
          m_y = f_op(opv, av, bv);
          m_cnt = 1;
          m_valid = 1'b1;
        end else begin
          if (q.size() == 0) m_bop = opv;
          q.push_back(av);
          if (il) begin
            r = q[0];
            for (int i = 1; i < q.size(); i++) r = f_op(m_bop, r, q[i]);
            m_y = r;
            m_cnt = q.size();
            m_valid = 1'b1;
            q.delete();
          end
        end
      end
    end
    #1;
    if (primed) begin
      chk("out_valid1", 32'(out_valid1), 32'(m_valid));
      chk("out_valid2", 32'(out_valid2), 32'(m_valid));
      chk("Y1", 32'(y1), 32'(m_y));
      chk("Y2", 32'(y2), 32'(m_y));
      chk("count1", 32'(count1), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
      chk("count2", 32'(count2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
`ifdef BLU_POPCOUNT_EN
      chk("popcnt1", 32'(popcnt1), 32'($countones(m_y)));
      chk("popcnt2", 32'(popcnt2), 32'($countones(m_y)));
`endif
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic [1:0] o,
                       input logic [7:0] x, input logic [7:0] z, input logic l);
    iv = v; md = m; opv = o; av = x; bv = z; il = l;
  endtask

  initial begin
    logic [7:0] pair_exp[4];
    m_valid = 1'b0; m_y = '0; m_cnt = 0; m_bop = '0; primed = 1'b0;
    rst = 1'b1; ordy = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);

    // Reset held 2 clocks with in_valid asserted.
    step(); step();
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_Y", 32'(y1), 32'd0);
    chk("rst_count", 32'(count1), 32'd0);
    rst = 1'b0;

    // Pairwise ops 0..3 on F0/3C.
    pair_exp[0] = 8'h30; pair_exp[1] = 8'hFC; pair_exp[2] = 8'hCC; pair_exp[3] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 2'(k), 8'hF0, 8'h3C, 1'b0);
      step();
      chk("pair_Y", 32'(y1), 32'(pair_exp[k]));
      chk("pair_count", 32'(count1), 32'd1);
    end

    // OR burst of 01,02,04,08.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'd1, 8'(1 << k), 8'h00, k == 3);
      step();
      if (k < 3) chk("burst_quiet", 32'(out_valid1), 32'd0);
    end
    chk("burst_Y", 32'(y1), 32'h0F);
    chk("burst_count", 32'(count1), 32'd4);

    // Backpressure: pending result blocks input, then pop and load in the same clock.
    drive(1'b1, 1'b0, 2'd1, 8'h12, 8'h34, 1'b0);
    ordy = 1'b0;
    step();
    chk("bp_in_ready", 32'(in_ready1), 32'd0);
    chk("bp_Y_hold", 32'(y1), 32'h0F);
    chk("bp_count_hold", 32'(count1), 32'd4);
    ordy = 1'b1;
    step();
    chk("bp_new_Y", 32'(y1), 32'h36);
    chk("bp_new_count", 32'(count1), 32'd1);
    chk("bp_new_valid", 32'(out_valid1), 32'd1);

    // Mid-burst reset discards the partial XOR accumulation.
    drive(1'b1, 1'b1, 2'd2, 8'hAA, 8'h00, 1'b0); step();
    drive(1'b1, 1'b1, 2'd2, 8'hFF, 8'h00, 1'b0); step();
    rst = 1'b1; step(); rst = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 8'h5A, 8'h00, 1'b1); step();
    chk("mid_rst_Y", 32'(y1), 32'h5A);
    chk("mid_rst_count", 32'(count1), 32'd1);

    // op change inside a burst is ignored.
    drive(1'b1, 1'b1, 2'd2, 8'hAA, 8'h00, 1'b0); step();
    drive(1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 1'b1); step();
    chk("op_ignore_Y", 32'(y1), 32'h55);
    chk("op_ignore_count", 32'(count1), 32'd2);

    // 6-beat AND burst of FF: CNT_W=2 saturates at 3.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 2'd0, 8'hFF, 8'h00, k == 5);
      step();
    end
    chk("sat_Y", 32'(y2), 32'hFF);
    chk("sat_count2", 32'(count2), 32'd3);
    chk("sat_count1", 32'(count1), 32'd6);
`ifdef BLU_POPCOUNT_EN
    chk("sat_popcnt", 32'(popcnt2), 32'd8);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
